// File: rtl/vga_timing_defs.sv
// Shared VGA timing package: 640x480@60 constants, derived totals and sync
// start positions, receiver FSM encodings, and a small saturating helper.
// The VGA generator uses the same package.
package vga_timing_defs;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_HLOCK  = 2'd1,
    ST_LOCKED = 2'd2
  } rx_state_e;

  // 10-bit increment that sticks at all-ones
  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_sync_edge_det.sv
// Two-flop sync sampler with asserted-edge detect. POL is the asserted level.
// The edge is flagged in the cycle where the first flop shows the asserted
// level and the second flop does not.
module vga_sync_edge_det #(
  parameter logic POL = 1'b0
) (
  input  logic pclk,
  input  logic rst,
  input  logic s_in,
  output logic s_edge
);

  logic s_d, s_q, s2_d, s_q2;

  // next values: plain shift
  always_comb begin
    s_d  = s_in;
    s2_d = s_q;
  end

  // sampler flops reset to the idle level so reset release never fakes an edge
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      s_q  <= ~POL;
      s_q2 <= ~POL;
    end else begin
      s_q  <= s_d;
      s_q2 <= s2_d;
    end
  end

  assign s_edge = (s_q == POL) && (s_q2 != POL);

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: locks a local hcount/vcount reconstruction onto incoming
// hsync/vsync, regenerates display/eof, flags lock, sync errors and loss of
// signal. Optional line/frame period measurement under VGA_RX_MEASURE_EN.
module vga_sync_receiver
  import vga_timing_defs::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int LOCK_LINES = 4
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] hcount_rx,
  output logic [9:0] vcount_rx,
  output logic       display_rx,
  output logic       eof_rx,
  output logic       locked,
  output logic       sync_err,
  output logic       no_signal,
  output logic [9:0] meas_htotal,
  output logic [9:0] meas_vtotal
);

  localparam int         MW        = $clog2(LOCK_LINES + 1);
  localparam logic [9:0] H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
  localparam logic [10:0] WD_LIMIT = 11'(2 * (H_ACTIVE + H_FP + H_SYNC + H_BP));

  logic hs_edge, vs_edge;

  vga_sync_edge_det #(.POL(1'(HSYNC_POL))) u_hs (
    .pclk(pclk), .rst(rst), .s_in(hsync_in), .s_edge(hs_edge)
  );
  vga_sync_edge_det #(.POL(1'(VSYNC_POL))) u_vs (
    .pclk(pclk), .rst(rst), .s_in(vsync_in), .s_edge(vs_edge)
  );

  rx_state_e     state_q, state_d;
  logic [9:0]    hcount_q, hcount_d, vcount_q, vcount_d;
  logic [MW-1:0] match_q, match_d;
  logic          locked_q, locked_d;
  logic [10:0]   wdog_q, wdog_d;
  logic          err_c;

  // state register; watchdog resets saturated so no_signal starts high
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_SEARCH;
      hcount_q <= '0;
      vcount_q <= '0;
      match_q  <= '0;
      locked_q <= 1'b0;
      wdog_q   <= 11'h7FF;
    end else begin
      state_q  <= state_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      match_q  <= match_d;
      locked_q <= locked_d;
      wdog_q   <= wdog_d;
    end
  end

  // next state: free-running counters, realigned by hsync only while searching
  always_comb begin
    logic h_at, v_at, h_wrap;
    h_at     = (hcount_q == HS_START);
    v_at     = (hcount_q == 10'd0) && (vcount_q == VS_START);
    h_wrap   = (hcount_q == H_LAST);
    hcount_d = h_wrap ? 10'd0 : hcount_q + 10'd1;
    vcount_d = h_wrap ? ((vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1) : vcount_q;
    state_d  = state_q;
    match_d  = match_q;
    err_c    = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        if (hs_edge) begin
          hcount_d = HS_START + 10'd1;
          match_d  = h_at ? match_q + MW'(1) : MW'(1);
          if (match_d == MW'(LOCK_LINES)) state_d = ST_HLOCK;
        end
      end
      ST_HLOCK: begin
        err_c = (hs_edge != h_at) || (vs_edge && (hcount_q != 10'd0));
        if (!err_c && vs_edge) begin
          vcount_d = VS_START;
          state_d  = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        // h and v violations fold into one pulse
        err_c = (hs_edge != h_at) || (vs_edge != v_at);
      end
      default: state_d = ST_SEARCH;
    endcase
    if (err_c) begin
      state_d = ST_SEARCH;
      match_d = '0;
    end
    locked_d = (state_d == ST_LOCKED);
    wdog_d   = hs_edge ? 11'd0 : ((wdog_q == 11'h7FF) ? wdog_q : wdog_q + 11'd1);
  end

  // outputs decoded from registered state
  always_comb begin
    sync_err   = err_c;
    display_rx = locked_q && (hcount_q < H_ACT) && (vcount_q < V_ACT);
    eof_rx     = locked_q && (hcount_q == H_ACT) && (vcount_q == V_ACT);
    no_signal  = (wdog_q >= WD_LIMIT);
  end

  assign hcount_rx = hcount_q;
  assign vcount_rx = vcount_q;
  assign locked    = locked_q;

`ifdef VGA_RX_MEASURE_EN
  logic [9:0] hper_q, hper_d, hmeas_q, hmeas_d;
  logic [9:0] vlines_q, vlines_d, vmeas_q, vmeas_d;
  logic       hseen_q, hseen_d, vseen_q, vseen_d;

  // measurement next values; the first edge after reset only arms the measure
  always_comb begin
    hper_d   = hs_edge ? 10'd1 : sat_inc10(hper_q);
    hmeas_d  = (hs_edge && hseen_q) ? hper_q : hmeas_q;
    hseen_d  = hseen_q | hs_edge;
    vlines_d = vs_edge ? 10'd0 : (hs_edge ? sat_inc10(vlines_q) : vlines_q);
    vmeas_d  = (vs_edge && vseen_q) ? vlines_q : vmeas_q;
    vseen_d  = vseen_q | vs_edge;
  end

  // measurement registers
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hper_q   <= '0;
      hmeas_q  <= '0;
      hseen_q  <= 1'b0;
      vlines_q <= '0;
      vmeas_q  <= '0;
      vseen_q  <= 1'b0;
    end else begin
      hper_q   <= hper_d;
      hmeas_q  <= hmeas_d;
      hseen_q  <= hseen_d;
      vlines_q <= vlines_d;
      vmeas_q  <= vmeas_d;
      vseen_q  <= vseen_d;
    end
  end

  assign meas_htotal = hmeas_q;
  assign meas_vtotal = vmeas_q;
`else
  assign meas_htotal = '0;
  assign meas_vtotal = '0;
`endif

endmodule

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Sink-side counterpart of the VGA timing generator.
- Samples incoming hsync/vsync and locks a local timing reconstruction onto them.
- Regenerates hcount/vcount/display/eof aligned to the source, and flags lock, timing errors and signal loss.
- Sits behind the capture pins (or in loopback after the generator) and feeds downstream pixel sinks and checkers.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse lines
- V_BP, 33, vertical back porch
- HSYNC_POL, 0, asserted level of hsync_in
- VSYNC_POL, 0, asserted level of vsync_in
- LOCK_LINES, 4, consecutive correctly spaced hsync edges required for horizontal lock

Ports:
- pclk  in  1  pixel clock
- rst  in  1  reset; asynchronous, active-low
- hsync_in  in  1  incoming horizontal sync
- vsync_in  in  1  incoming vertical sync
- hcount_rx  out  10  reconstructed pixel counter
- vcount_rx  out  10  reconstructed line counter
- display_rx  out  1  active-video flag
- eof_rx  out  1  end-of-frame strobe
- locked  out  1  full H+V lock
- sync_err  out  1  one-cycle pulse on any sync violation
- no_signal  out  1  no hsync edge within timeout
- meas_htotal  out  10  measured line period (see Optional Feature)
- meas_vtotal  out  10  measured lines per frame (see Optional Feature)

Behaviour:
- Derived constants: H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525); HS_START = H_ACTIVE+H_FP (656); VS_START = V_ACTIVE+V_FP (490).
- Input stage: each sync passes through two flops (s_q, s_q2). An edge is flagged in the cycle where s_q == POL and s_q2 != POL.
- Alignment: the first asserted hsync_q sample corresponds to source hcount 656. hcount_rx therefore equals the source hcount delayed by exactly 1 pclk.
- Counters:
  - hcount_rx wraps H_TOTAL-1 -> 0.
  - vcount_rx increments on each h wrap and wraps V_TOTAL-1 -> 0.
- Reset (async): hcount_rx=0, vcount_rx=0, locked=0, sync_err=0, no_signal=1, eof_rx=0, display_rx=0, meas_*=0, FSM=SEARCH, match counter=0.
- FSM states:
  - SEARCH:
    - On every hsync edge, the next hcount_rx is HS_START+1.
    - If the edge occurs while hcount_rx==HS_START, increment the match count; otherwise set it to 1.
    - When the match count reaches LOCK_LINES, go to HLOCK.
  - HLOCK:
    - hsync edge with hcount_rx!=HS_START, or no edge at hcount_rx==HS_START: sync_err pulse, go to SEARCH.
    - vsync edge with hcount_rx==0: next vcount_rx is VS_START, go to LOCKED.
    - vsync edge with hcount_rx!=0: sync_err pulse, go to SEARCH.
  - LOCKED:
    - locked=1 (registered; asserted the cycle after entering LOCKED).
    - Error conditions: hsync edge at the wrong hcount_rx; missing hsync edge at hcount_rx==HS_START; vsync edge not at (0,VS_START); missing vsync edge at (0,VS_START).
    - Any error: sync_err pulses for 1 cycle, next state is SEARCH, locked deasserts the next cycle, and counters keep running.
- Simultaneous hsync and vsync errors: a single sync_err pulse.
- display_rx = locked && hcount_rx<H_ACTIVE && vcount_rx<V_ACTIVE.
- eof_rx = locked && hcount_rx==H_ACTIVE && vcount_rx==V_ACTIVE.
- no_signal watchdog:
  - 11-bit saturating counter of cycles since the last hsync edge; it clears on an edge.
  - no_signal=1 while the count >= 2*H_TOTAL.
- Reset mid-operation: immediate return to reset values; re-acquisition starts from SEARCH.

Optional Feature:
- Macro: VGA_RX_MEASURE_EN.
- When defined:
  - meas_htotal is updated on each hsync edge with the cycle count since the previous edge.
  - meas_vtotal is updated on each vsync edge with the hsync-edge count since the previous vsync edge.
  - Both saturate at 1023. The first measurement after reset is discarded (outputs hold 0 until the second edge).
- When not defined: the ports remain and are tied to 0, and no measurement logic is built.

Decomposition:
- Shared include/package vga_timing_defs holds the 640x480@60 timing constants, the derived H_TOTAL/V_TOTAL/HS_START/VS_START, and the FSM state encodings. The existing generator uses the same file.
- One sub-module, vga_sync_edge_det: two-flop sampler plus asserted-edge detect, with a polarity parameter. It is instantiated for hsync and for vsync.

Test Plan:
- Reset: hold rst=0 for 10 cycles -> hcount_rx=0, vcount_rx=0, locked=0, sync_err=0, no_signal=1, display_rx=0, eof_rx=0.
- Loopback from the VGA generator for 3 frames:
  - locked rises after 4 matching lines plus the first vsync.
  - Thereafter hcount_rx/vcount_rx/display_rx equal the generator outputs delayed 1 pclk.
  - eof_rx pulses exactly once per frame and sync_err stays 0.
- While locked, shift one hsync pulse 1 cycle early -> one sync_err pulse; locked=0 next cycle; relock by the next vsync once 4 matching lines precede it.
- While locked, suppress one hsync pulse -> sync_err in the cycle where hcount_rx==656, and the FSM returns to SEARCH.
- Hold hsync_in inactive 2000 cycles -> no_signal=1 from 1600 cycles after the last edge; sync_err pulses at the first missed position; locked=0.
- With VGA_RX_MEASURE_EN defined, run 3 generator frames -> meas_htotal=800, meas_vtotal=525; without the macro, both stay 0.
